// File: rtl/median_stream_3_pkg.sv
// Shared constants for the 3-tap median stream filter: sample width, the
// "no echo" code, fill-level encoding and the default idle timeout.
package median_stream_3_pkg;

  localparam int unsigned MS3_WIDTH          = 20;
  localparam logic [19:0] MS3_INVALID_VALUE  = 20'hFFFFF;
  localparam int unsigned MS3_TIMEOUT_CYCLES = 27_000_000;

  // Window fill levels; 1 and 2 are both FILLING, FILL_FILLING marks the first.
  localparam logic [1:0] FILL_EMPTY   = 2'd0;
  localparam logic [1:0] FILL_FILLING = 2'd1;
  localparam logic [1:0] FILL_PRIMED  = 2'd3;

endpackage

// File: rtl/median_stream_3_median_3.sv
// Combinational median of three unsigned values; ties resolve to the
// duplicated value because the result is always one of the inputs.
module median_3 #(
  parameter int unsigned WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] m
);

  logic [WIDTH-1:0] lo_ab;
  logic [WIDTH-1:0] hi_ab;
  logic [WIDTH-1:0] lo_hc;

  always_comb begin
    lo_ab = (a < b) ? a : b;
    hi_ab = (a < b) ? b : a;
    lo_hc = (hi_ab < c) ? hi_ab : c;
    m     = (lo_ab > lo_hc) ? lo_ab : lo_hc;
  end

endmodule

// File: rtl/median_stream_3.sv
// Sliding 3-sample median filter that drops "no echo" readings.
// Optional idle-timeout window clear is built when STALE_TIMEOUT_EN is defined.
//
// state   | meaning
// EMPTY   | fill == 0, no samples held
// FILLING | fill == 1 or 2, window partially loaded, no medians yet
// PRIMED  | fill == 3, every accept emits a median
module median_stream_3
  import median_stream_3_pkg::*;
#(
  parameter int unsigned      WIDTH         = MS3_WIDTH,
  parameter logic [WIDTH-1:0] INVALID_VALUE = WIDTH'(MS3_INVALID_VALUE)
`ifdef STALE_TIMEOUT_EN
  ,
  parameter int unsigned      TIMEOUT_CYCLES = MS3_TIMEOUT_CYCLES
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] median_out,
  output logic             median_valid,
  output logic             primed,
  output logic [7:0]       dropped_count,
  output logic             stale
);

  logic [WIDTH-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [WIDTH-1:0] median_q, median_d, median_w;
  logic [1:0]       fill_q, fill_d;
  logic             median_valid_q, median_valid_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             accept, reject, timeout;

  median_3 #(.WIDTH(WIDTH)) u_median_3 (
    .a (sample_in),
    .b (w0_q),
    .c (w1_q),
    .m (median_w)
  );

  always_comb begin
    accept         = sample_valid && !flush && (sample_in != INVALID_VALUE);
    reject         = sample_valid && !flush && (sample_in == INVALID_VALUE);
    w0_d           = w0_q;
    w1_d           = w1_q;
    w2_d           = w2_q;
    fill_d         = fill_q;
    median_d       = median_q;
    median_valid_d = 1'b0;
    dropped_d      = dropped_q;

    // timeout is never raised in a cycle that accepts, so accept wins
    if (flush || timeout) begin
      w0_d   = '0;
      w1_d   = '0;
      w2_d   = '0;
      fill_d = FILL_EMPTY;
    end else if (accept) begin
      w0_d = sample_in;
      w1_d = w0_q;
      w2_d = w1_q;
      if (fill_q != FILL_PRIMED) fill_d = fill_q + 2'd1;
      if (fill_q >= FILL_PRIMED - 2'd1) begin
        median_d       = median_w;
        median_valid_d = 1'b1;
      end
    end

    if (reject && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w0_q           <= '0;
      w1_q           <= '0;
      w2_q           <= '0;
      fill_q         <= FILL_EMPTY;
      median_q       <= '0;
      median_valid_q <= 1'b0;
      dropped_q      <= '0;
    end else begin
      w0_q           <= w0_d;
      w1_q           <= w1_d;
      w2_q           <= w2_d;
      fill_q         <= fill_d;
      median_q       <= median_d;
      median_valid_q <= median_valid_d;
      dropped_q      <= dropped_d;
    end
  end

`ifdef STALE_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_q, idle_d;
  logic          stale_q, stale_d;

  // Down-counter reloaded on every accept; terminal count zero means the
  // window has sat idle for TIMEOUT_CYCLES cycles.
  always_comb begin
    idle_d  = idle_q;
    stale_d = stale_q;
    timeout = 1'b0;
    if (flush) begin
      idle_d  = IDLE_LOAD;
      stale_d = 1'b0;
    end else if (accept) begin
      idle_d  = IDLE_LOAD;
      stale_d = 1'b0;
    end else if (fill_q >= FILL_FILLING) begin
      if (idle_q == '0) begin
        timeout = 1'b1;
        stale_d = 1'b1;
        idle_d  = IDLE_LOAD;
      end else begin
        idle_d = idle_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      stale_q <= stale_d;
    end
  end

  assign stale = stale_q;
`else
  assign timeout = 1'b0;
  assign stale   = 1'b0;
`endif

  assign median_out    = median_q;
  assign median_valid  = median_valid_q;
  assign primed        = (fill_q == FILL_PRIMED);
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_median_stream_3.sv
// Scoreboard bench for median_stream_3: directed samples push hand-computed
// medians; a monitor pops and compares on every median_valid pulse.
module tb_median_stream_3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        flush = 1'b0;
  logic [19:0] median_out;
  logic        median_valid;
  logic        primed;
  logic [7:0]  dropped_count;
  logic        stale;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  always #5 clock = ~clock;

`ifdef STALE_TIMEOUT_EN
  median_stream_3 #(.TIMEOUT_CYCLES(10)) dut (
`else
  median_stream_3 dut (
`endif
    .clock         (clock),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .flush         (flush),
    .median_out    (median_out),
    .median_valid  (median_valid),
    .primed        (primed),
    .dropped_count (dropped_count),
    .stale         (stale)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [19:0] v, input bit pulse, input logic [19:0] exp);
    sample_in    = v;
    sample_valid = 1'b1;
    if (pulse) exp_q.push_back(exp);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 20'd999;
    @(posedge clock);
    #1;
    flush        = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic run_monitor();
    forever begin
      @(negedge clock);
      if (median_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {12'd0, median_out}, 32'hFFFF_FFFF);
        end else begin
          check("median_out", {12'd0, median_out}, {12'd0, exp_q.pop_front()});
        end
      end
    end
  endtask

  task automatic run_stim();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_median_out", {12'd0, median_out}, 0);
    check("rst_median_valid", {31'd0, median_valid}, 0);
    check("rst_primed", {31'd0, primed}, 0);
    check("rst_dropped", {24'd0, dropped_count}, 0);
    check("rst_stale", {31'd0, stale}, 0);

    // basic fill then sliding window
    send(20'd100, 0, 0);
    send(20'd300, 0, 0);
    check("primed_before_third", {31'd0, primed}, 0);
    send(20'd200, 1, 20'd200);
    check("primed_after_third", {31'd0, primed}, 1);
    send(20'd50,  1, 20'd200);
    send(20'd400, 1, 20'd200);
    send(20'd10,  1, 20'd50);

    // invalid sample leaves window {10,400,50} untouched
    send(20'hFFFFF, 0, 0);
    check("dropped_one", {24'd0, dropped_count}, 1);
    send(20'd60, 1, 20'd60);
    for (int i = 0; i < 300; i++) send(20'hFFFFF, 0, 0);
    check("dropped_sat", {24'd0, dropped_count}, 255);
    check("primed_after_invalid", {31'd0, primed}, 1);

    // flush wins over a simultaneous sample
    do_flush();
    check("flush_primed", {31'd0, primed}, 0);
    check("flush_median_hold", {12'd0, median_out}, 60);
    check("flush_dropped_kept", {24'd0, dropped_count}, 255);
    send(20'd7, 0, 0);
    send(20'd9, 0, 0);
    send(20'd7, 1, 20'd7);

    // ties
    do_flush();
    send(20'd5, 0, 0);
    send(20'd5, 0, 0);
    send(20'd5, 1, 20'd5);
    send(20'd8, 1, 20'd5);
    send(20'd8, 1, 20'd8);

    // reset mid-fill, overriding a simultaneous sample and flush
    do_flush();
    send(20'd11, 0, 0);
    send(20'd12, 0, 0);
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_in = 20'd77;
    flush = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sample_valid = 1'b0;
    flush = 1'b0;
    check("mid_rst_median_out", {12'd0, median_out}, 0);
    check("mid_rst_dropped", {24'd0, dropped_count}, 0);
    check("mid_rst_primed", {31'd0, primed}, 0);
    send(20'd1, 0, 0);
    send(20'd2, 0, 0);
    send(20'd3, 1, 20'd2);

    // idle timeout
    do_flush();
    send(20'd20, 0, 0);
    send(20'd30, 0, 0);
    repeat (9) @(posedge clock);
    #1;
    check("stale_at_9_idle", {31'd0, stale}, 0);
    @(posedge clock);
    #1;
`ifdef STALE_TIMEOUT_EN
    check("stale_at_10_idle", {31'd0, stale}, 1);
    send(20'd40, 0, 0);
    check("stale_cleared", {31'd0, stale}, 0);
    send(20'd50, 0, 0);
    send(20'd60, 1, 20'd50);
`else
    check("stale_at_10_idle", {31'd0, stale}, 0);
    send(20'd40, 1, 20'd30);
    check("stale_still_zero", {31'd0, stale}, 0);
`endif
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    fork
      run_monitor();
      run_stim();
    join_any
    disable fork;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
